vga_timing_gen: RTL and testbench

Raster timing generator for the 640x480@60 Hz display path. It runs on the 25 MHz pixel clock and produces the horizontal and vertical sync pulses, the active-video flag `blank` and the pixel coordinates `DrawX`/`DrawY`. These feed the sprite/colour mappers directly downstream, which register `DrawX`, `DrawY` and `blank` to produce `red`/`green`/`blue`.

---
 rtl/vga_timing_gen_pkg.sv | 26 ++
 rtl/vga_timing_gen_sync_delay.sv | 24 ++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants and coordinate type for the 640x480@60 timing path.
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Largest total a 10-bit counter can sweep without aliasing.
  localparam int COORD_RANGE = 1024;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Half-open window test [lo, hi) on raster coordinates.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Parameterised-depth 1-bit shift register; every stage resets to 1 (sync idle level).
module sync_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH:0] chain;

  assign chain[0] = d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) chain[i+1] <= 1'b1;
      else     chain[i+1] <= chain[i];
    end
  end

  assign q = chain[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: hc/vc counters with registered sync, blank and coordinate decodes.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs by SYNC_DELAY cycles to match the colour mapper.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_END  = coord_t'(H_VISIBLE);
  localparam coord_t V_ACT_END  = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_ON  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_OFF = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_SYNC_ON  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_OFF = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed %0d", COORD_RANGE);
  end
  if (SYNC_DELAY < 0) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be non-negative");
  end

  coord_t hc, vc;
  logic   hs_line, vs_line;

  // Raster counters: hc sweeps each line, vc advances on the last pixel of a line.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? coord_t'(0) : vc + coord_t'(1);
    end else begin
      hc <= hc + coord_t'(1);
    end
  end

  // Registered decodes; coordinates are deliberately left unclamped through blanking.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs_line     <= 1'b1;
      vs_line     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= hc;
      DrawY       <= vc;
      blank       <= (hc < H_ACT_END) && (vc < V_ACT_END);
      hs_line     <= !in_window(hc, H_SYNC_ON, H_SYNC_OFF);
      vs_line     <= !in_window(vc, V_SYNC_ON, V_SYNC_OFF);
      frame_start <= (hc == '0) && (vc == '0);
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  if (SYNC_DELAY < 1) begin : g_bad_align
    $error("vga_timing_gen: SYNC_DELAY must be >= 1 when sync alignment is enabled");
  end

  // Extra stages line sync edges up with the mapper's ROM + colour register.
  sync_delay #(.DEPTH(SYNC_DELAY)) u_hs_delay (
    .clk (vga_clk),
    .rst (reset),
    .d   (hs_line),
    .q   (hs)
  );

  sync_delay #(.DEPTH(SYNC_DELAY)) u_vs_delay (
    .clk (vga_clk),
    .rst (reset),
    .d   (vs_line),
    .q   (vs)
  );
`else
  assign hs = hs_line;
  assign vs = vs_line;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-size and reduced-size generators against an arithmetic raster model.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  localparam int A_HT = 800, A_VT = 525;
  localparam int B_HT = 50,  B_VT = 27;
  localparam int B_FRAME = B_HT * B_VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  localparam obs_t RST = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic hs_a, vs_a, blank_a, fs_a, hs_b, vs_b, blank_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  obs_t obs_a, obs_b;

  int total = 0;
  int bad   = 0;

  vga_timing_gen u_a (
    .vga_clk(clk), .reset(rst_a), .hs(hs_a), .vs(vs_a), .blank(blank_a),
    .DrawX(x_a), .DrawY(y_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
    .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_b (
    .vga_clk(clk), .reset(rst_b), .hs(hs_b), .vs(vs_b), .blank(blank_b),
    .DrawX(x_b), .DrawY(y_b), .frame_start(fs_b)
  );

  assign obs_a = '{x: x_a, y: y_a, blank: blank_a, hs: hs_a, vs: vs_a, fs: fs_a};
  assign obs_b = '{x: x_b, y: y_b, blank: blank_b, hs: hs_b, vs: vs_b, fs: fs_b};

  // Expected outputs t cycles after the first edge following reset release.
  function automatic obs_t model(input int t, input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb);
    obs_t o;
    int ht, vt, p, ps, sx, sy;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = t % (ht * vt);
    o.x     = 10'(p % ht);
    o.y     = 10'(p / ht);
    o.blank = ((p % ht) < hv) && ((p / ht) < vv);
    o.fs    = (p == 0);
    if (t < SD) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      ps = (t - SD) % (ht * vt);
      sx = ps % ht;
      sy = ps / ht;
      o.hs = !(sx >= hv + hf && sx < hv + hf + hsw);
      o.vs = !(sy >= vv + vf && sy < vv + vf + vsw);
    end
    return o;
  endfunction

  function automatic obs_t model_a(input int t);
    return model(t, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_b(input int t);
    return model(t, 32, 4, 8, 6, 20, 2, 2, 3);
  endfunction

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs_a !== RST) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs_a, RST); end
    total++;
    if (obs_b !== RST) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs_b, RST); end
    rst_a = 1'b0;
    @(negedge clk);
    total++;
    if (x_a !== 10'd0 || y_a !== 10'd0 || blank_a !== 1'b1 || fs_a !== 1'b1)
      begin bad++; $display("FAIL first_edge got=%h exp x=0 y=0 blank=1 fs=1", obs_a); end
    total++;
    if (hs_a !== 1'b1 || vs_a !== 1'b1)
      begin bad++; $display("FAIL first_edge_sync got hs=%b vs=%b exp 1 1", hs_a, vs_a); end
  endtask

  task automatic test_line_timing();
    int hs_low, blank_hi;
    hs_low = 0;
    blank_hi = 0;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    for (int t = 0; t < 3 * A_HT + 37; t++) begin
      @(negedge clk);
      total++;
      if (obs_a !== model_a(t)) begin
        bad++; $display("FAIL line_a t=%0d got=%h exp=%h", t, obs_a, model_a(t));
      end
      if (y_a == 10'd1 && !hs_a) hs_low++;
      if (y_a == 10'd1 && blank_a) blank_hi++;
    end
    total++;
    if (hs_low != 96) begin bad++; $display("FAIL hs_width got=%0d exp=96", hs_low); end
    total++;
    if (blank_hi != 640) begin bad++; $display("FAIL blank_width got=%0d exp=640", blank_hi); end
  endtask

  task automatic test_frame_timing();
    int fs_at[$];
    int vs_low;
    vs_low = 0;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int t = 0; t < 3 * B_FRAME; t++) begin
      @(negedge clk);
      total++;
      if (obs_b !== model_b(t)) begin
        bad++; $display("FAIL frame_b t=%0d got=%h exp=%h", t, obs_b, model_b(t));
      end
      if (fs_b) fs_at.push_back(t);
      if (t >= B_FRAME && t < 2 * B_FRAME && !vs_b) vs_low++;
    end
    total++;
    if (fs_at.size() != 3) begin
      bad++; $display("FAIL fs_count got=%0d exp=3", fs_at.size());
    end else begin
      total++;
      if (fs_at[1] - fs_at[0] != B_FRAME || fs_at[2] - fs_at[1] != B_FRAME) begin
        bad++; $display("FAIL fs_period got=%0d,%0d exp=%0d", fs_at[1] - fs_at[0], fs_at[2] - fs_at[1], B_FRAME);
      end
    end
    total++;
    if (vs_low != 2 * B_HT) begin bad++; $display("FAIL vs_width got=%0d exp=%0d", vs_low, 2 * B_HT); end
  endtask

  task automatic test_mid_frame_reset();
    int k;
    for (int it = 0; it < 5; it++) begin
      k = (it == 0) ? 13 * B_HT + 23 : int'($urandom_range(1, 2 * B_FRAME - 1));
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      for (int t = 0; t <= k; t++) begin
        @(negedge clk);
        total++;
        if (obs_b !== model_b(t)) begin
          bad++; $display("FAIL pre_rst_b it=%0d t=%0d got=%h exp=%h", it, t, obs_b, model_b(t));
        end
      end
      #2 rst_b = 1'b1;
      #1;
      total++;
      if (obs_b !== RST) begin bad++; $display("FAIL async_rst_b it=%0d got=%h exp=%h", it, obs_b, RST); end
      @(negedge clk);
      total++;
      if (obs_b !== RST) begin bad++; $display("FAIL held_rst_b it=%0d got=%h exp=%h", it, obs_b, RST); end
      rst_b = 1'b0;
      for (int t = 0; t < 2 * B_HT + 7; t++) begin
        @(negedge clk);
        total++;
        if (obs_b !== model_b(t)) begin
          bad++; $display("FAIL restart_b it=%0d t=%0d got=%h exp=%h", it, t, obs_b, model_b(t));
        end
      end
    end
  endtask

  task automatic test_mid_line_reset_default();
    int k;
    for (int it = 0; it < 2; it++) begin
      k = int'($urandom_range(1, 2 * A_HT));
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      repeat (k + 1) @(negedge clk);
      #3 rst_a = 1'b1;
      #1;
      total++;
      if (obs_a !== RST) begin bad++; $display("FAIL async_rst_a it=%0d got=%h exp=%h", it, obs_a, RST); end
      @(negedge clk);
      rst_a = 1'b0;
      for (int t = 0; t < A_HT + 20; t++) begin
        @(negedge clk);
        total++;
        if (obs_a !== model_a(t)) begin
          bad++; $display("FAIL restart_a it=%0d t=%0d got=%h exp=%h", it, t, obs_a, model_a(t));
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_mid_frame_reset();
    test_mid_line_reset_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
